control_seq: RTL

Parametrised multi-cycle instruction sequencer and the successor to the fixed four-state `controlsimple` sequencer. It walks each instruction through FETCH, DECODE, REGREAD, ALU, an optional MEM stage and REGWRITE, and it handshakes with memory for both instruction and data accesses. It also owns the program counter, the latched instruction word, branch redirection, pipeline stalls, halt and a retired-instruction counter. The datapath (`decode`, `alu`, `reg16_8`) takes its per-stage enables from the one-hot `state` output.

---
 rtl/control_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/control_seq.sv
// control_seq: multi-cycle instruction sequencer with memory handshake, PC, branch latch,
// stall, halt and retired-instruction counter; one-hot state drives datapath enables.
module control_seq #(
    parameter int PC_WIDTH = 16,
    parameter int INST_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  halt,
    input  logic                  is_mem,
    input  logic                  should_branch,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  mem_ack,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic [6:0]            state,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  mem_req,
    output logic                  mem_is_fetch,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [INST_WIDTH-1:0] mem_data,
    output logic [CNT_WIDTH-1:0]  retired
);
    localparam logic [6:0] S_FETCH    = 7'h01;
    localparam logic [6:0] S_DECODE   = 7'h02;
    localparam logic [6:0] S_REGREAD  = 7'h04;
    localparam logic [6:0] S_ALU      = 7'h08;
    localparam logic [6:0] S_MEM      = 7'h10;
    localparam logic [6:0] S_REGWRITE = 7'h20;
    localparam logic [6:0] S_HALT     = 7'h40;

    logic                br_taken;
    logic [PC_WIDTH-1:0] br_target;

    // memory outputs decode from registered state only
    assign mem_req      = state[0] | state[4];
    assign mem_is_fetch = state[0];
    assign mem_addr     = state[4] ? br_target : pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= '0;
            pc          <= RESET_PC;
            instruction <= '0;
            mem_data    <= '0;
            retired     <= '0;
            br_taken    <= 1'b0;
            br_target   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!stall) begin
                        state <= halt ? S_HALT : S_REGREAD;
                        if (halt)
                            retired <= retired + 1'b1;
                    end
                end
                S_REGREAD: begin
                    if (!stall)
                        state <= S_ALU;
                end
                S_ALU: begin
                    if (!stall) begin
                        br_taken  <= should_branch;
                        br_target <= branch_target;
                        state     <= is_mem ? S_MEM : S_REGWRITE;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_data <= mem_rdata;
                        state    <= S_REGWRITE;
                    end
                end
                S_REGWRITE: begin
                    if (!stall) begin
                        pc       <= br_taken ? br_target : pc + 1'b1;
                        retired  <= retired + 1'b1;
                        br_taken <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                // idle after reset (and any corrupted encoding) restarts at FETCH
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule
